// File: rtl/snax_dimc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : snax_dimc_seq_ctrl_if
// Brief    : CSR request/response and DIMC stream-gating bundle for the
//            DIMC sequence controller.
// Revision : 1.0 - initial release
// ============================================================================
interface snax_dimc_seq_ctrl_if #(
    parameter int RegAddrWidth = 32,
    parameter int RegDataWidth = 32
);
    logic [RegAddrWidth-1:0] csr_req_addr_i;
    logic [RegDataWidth-1:0] csr_req_data_i;
    logic                    csr_req_write_i;
    logic                    csr_req_valid_i;
    logic                    csr_req_ready_o;
    logic [RegDataWidth-1:0] csr_rsp_data_o;
    logic                    csr_rsp_valid_o;
    logic                    csr_rsp_ready_i;
    logic                    in_fire_i;
    logic                    out_fire_i;
    logic                    in_allow_o;
    logic                    out_allow_o;
    logic [1:0]              dimc_mode_o;
    logic                    busy_o;
    logic                    done_o;

    modport slave (
        input  csr_req_addr_i, csr_req_data_i, csr_req_write_i, csr_req_valid_i,
        input  csr_rsp_ready_i, in_fire_i, out_fire_i,
        output csr_req_ready_o, csr_rsp_data_o, csr_rsp_valid_o,
        output in_allow_o, out_allow_o, dimc_mode_o, busy_o, done_o
    );

    modport master (
        output csr_req_addr_i, csr_req_data_i, csr_req_write_i, csr_req_valid_i,
        output csr_rsp_ready_i, in_fire_i, out_fire_i,
        input  csr_req_ready_o, csr_rsp_data_o, csr_rsp_valid_o,
        input  in_allow_o, out_allow_o, dimc_mode_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/snax_dimc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snax_dimc_seq_ctrl
// Brief    : CSR-programmed job sequencer gating DIMC input/output beats.
// Revision : 1.0 - initial release
// ============================================================================
module snax_dimc_seq_ctrl #(
    parameter int RegAddrWidth = 32,
    parameter int RegDataWidth = 32,
    parameter int CntWidth     = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    snax_dimc_seq_ctrl_if.slave bus
);

    localparam logic [RegAddrWidth-1:0] c_ADDR_MODE    = RegAddrWidth'(0);
    localparam logic [RegAddrWidth-1:0] c_ADDR_NUM_IN  = RegAddrWidth'(1);
    localparam logic [RegAddrWidth-1:0] c_ADDR_NUM_OUT = RegAddrWidth'(2);
    localparam logic [RegAddrWidth-1:0] c_ADDR_START   = RegAddrWidth'(3);
    localparam logic [RegAddrWidth-1:0] c_ADDR_STATUS  = RegAddrWidth'(4);
    localparam logic [RegAddrWidth-1:0] c_ADDR_PERF    = RegAddrWidth'(5);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [1:0]              r_mode_cfg;
    logic [1:0]              r_dimc_mode;
    logic [CntWidth-1:0]     r_num_in;
    logic [CntWidth-1:0]     r_num_out;
    logic [CntWidth-1:0]     r_in_cnt;
    logic [CntWidth-1:0]     r_out_cnt;
    logic [RegDataWidth-1:0] r_perf;
    logic                    r_done_sticky;
    logic                    r_rsp_valid;
    logic [RegDataWidth-1:0] r_rsp_data;

    logic                    w_req_ready;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_start;
    logic                    w_in_allow;
    logic                    w_out_allow;
    logic                    w_busy;
    logic                    w_done;
    logic [RegDataWidth-1:0] w_rd_data;
    logic                    w_unused;

    // A new request may be taken whenever the response slot is free or draining.
    assign w_req_ready = !r_rsp_valid || bus.csr_rsp_ready_i;
    assign w_wr        = bus.csr_req_valid_i && w_req_ready && bus.csr_req_write_i;
    assign w_rd        = bus.csr_req_valid_i && w_req_ready && !bus.csr_req_write_i;
    assign w_start     = w_wr && (bus.csr_req_addr_i == c_ADDR_START) &&
                         bus.csr_req_data_i[0] && (r_state == S_IDLE);
    assign w_unused    = &{1'b0, bus.csr_req_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_allow   = 1'b0;
        w_out_allow  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy      = 1'b1;
                w_in_allow  = (r_in_cnt != r_num_in);
                w_out_allow = (r_out_cnt != r_num_out);
                if ((r_in_cnt == r_num_in) && (r_out_cnt == r_num_out)) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.csr_req_addr_i)
            c_ADDR_MODE:    w_rd_data = RegDataWidth'(r_mode_cfg);
            c_ADDR_NUM_IN:  w_rd_data = RegDataWidth'(r_num_in);
            c_ADDR_NUM_OUT: w_rd_data = RegDataWidth'(r_num_out);
            c_ADDR_STATUS:  w_rd_data = RegDataWidth'({r_done_sticky, w_busy});
            c_ADDR_PERF:    w_rd_data = r_perf;
            default:        w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode_cfg    <= '0;
            r_dimc_mode   <= '0;
            r_num_in      <= '0;
            r_num_out     <= '0;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_perf        <= '0;
            r_done_sticky <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
        end else begin
            // Job configuration is frozen for the whole job.
            if (w_wr && !w_busy) begin
                if (bus.csr_req_addr_i == c_ADDR_MODE) begin
                    r_mode_cfg <= bus.csr_req_data_i[1:0];
                end
                if (bus.csr_req_addr_i == c_ADDR_NUM_IN) begin
                    r_num_in <= bus.csr_req_data_i[CntWidth-1:0];
                end
                if (bus.csr_req_addr_i == c_ADDR_NUM_OUT) begin
                    r_num_out <= bus.csr_req_data_i[CntWidth-1:0];
                end
            end

            if (w_start) begin
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_perf      <= '0;
                r_dimc_mode <= r_mode_cfg;
            end else if (r_state == S_RUN) begin
                if (bus.in_fire_i && w_in_allow) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
                if (bus.out_fire_i && w_out_allow) begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
                if (r_perf != '1) begin
                    r_perf <= r_perf + 1'b1;
                end
            end

            // Completion takes priority over a concurrent clear-on-read.
            if (w_start) begin
                r_done_sticky <= 1'b0;
            end else if (r_state == S_FINISH) begin
                r_done_sticky <= 1'b1;
            end else if (w_rd && (bus.csr_req_addr_i == c_ADDR_STATUS)) begin
                r_done_sticky <= 1'b0;
            end

            if (w_rd) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rd_data;
            end else if (bus.csr_rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.csr_req_ready_o = w_req_ready;
    assign bus.csr_rsp_valid_o = r_rsp_valid;
    assign bus.csr_rsp_data_o  = r_rsp_data;
    assign bus.in_allow_o      = w_in_allow;
    assign bus.out_allow_o     = w_out_allow;
    assign bus.dimc_mode_o     = r_dimc_mode;
    assign bus.busy_o          = w_busy;
    assign bus.done_o          = w_done;

endmodule
`default_nettype wire

// File: tb/tb_snax_dimc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snax_dimc_seq_ctrl
// Brief    : Scoreboard bench for the DIMC sequence controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_dimc_seq_ctrl;

    localparam int c_AW = 32;
    localparam int c_DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snax_dimc_seq_ctrl_if #(.RegAddrWidth(c_AW), .RegDataWidth(c_DW)) bus ();

    snax_dimc_seq_ctrl #(
        .RegAddrWidth(c_AW),
        .RegDataWidth(c_DW),
        .CntWidth    (16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          d0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response handshakes complete on the edge after this sample point.
    always @(negedge clk) begin
        if (!rst && bus.done_o) done_cnt++;
        if (!rst && bus.csr_rsp_valid_o && bus.csr_rsp_ready_i) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else                   check("rsp_data", bus.csr_rsp_data_o, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_req(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                           input logic [31:0] exp, input logic push);
        logic ok;
        ok = 1'b0;
        bus.csr_req_addr_i  = addr;
        bus.csr_req_data_i  = data;
        bus.csr_req_write_i = wr;
        bus.csr_req_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.csr_req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
        else if (!wr && push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.csr_req_valid_i = 1'b0;
        bus.csr_req_write_i = 1'b0;
    endtask

    task automatic wait_rsp();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !bus.csr_rsp_valid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic csr_wr(input logic [31:0] addr, input logic [31:0] data);
        csr_req(addr, data, 1'b1, 32'd0, 1'b0);
    endtask

    task automatic csr_rd(input logic [31:0] addr, input logic [31:0] exp);
        csr_req(addr, 32'd0, 1'b0, exp, 1'b1);
        wait_rsp();
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check(tag, 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.csr_rsp_valid_o), 32'd0);
        check({tag, "_in_allow"},  32'(bus.in_allow_o),      32'd0);
        check({tag, "_out_allow"}, 32'(bus.out_allow_o),     32'd0);
        check({tag, "_busy"},      32'(bus.busy_o),          32'd0);
        check({tag, "_done"},      32'(bus.done_o),          32'd0);
        check({tag, "_mode"},      32'(bus.dimc_mode_o),     32'd0);
        check({tag, "_rsp_data"},  bus.csr_rsp_data_o,       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        bus.csr_req_addr_i  = '0;
        bus.csr_req_data_i  = '0;
        bus.csr_req_write_i = 1'b0;
        bus.csr_req_valid_i = 1'b0;
        bus.csr_rsp_ready_i = 1'b1;
        bus.in_fire_i       = 1'b0;
        bus.out_fire_i      = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        check("reset_req_ready", 32'(bus.csr_req_ready_o), 32'd1);
        rst = 1'b0;
        tick();

        // Basic job: 4 in beats, 2 out beats, mode 1.
        csr_wr(0, 1);
        csr_wr(1, 4);
        csr_wr(2, 2);
        csr_rd(0, 1);
        csr_rd(1, 4);
        csr_rd(2, 2);
        d0 = done_cnt;
        csr_wr(3, 1);
        check("t1_busy",      32'(bus.busy_o),      32'd1);
        check("t1_mode",      32'(bus.dimc_mode_o), 32'd1);
        check("t1_in_allow",  32'(bus.in_allow_o),  32'd1);
        check("t1_out_allow", 32'(bus.out_allow_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.in_fire_i  = 1'b1;
            bus.out_fire_i = (i < 2);
            tick();
        end
        bus.in_fire_i  = 1'b0;
        bus.out_fire_i = 1'b0;
        check("t1_in_allow_end",  32'(bus.in_allow_o),  32'd0);
        check("t1_out_allow_end", 32'(bus.out_allow_o), 32'd0);
        wait_idle("t1_idle_timeout");
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        csr_rd(4, 32'h2);
        csr_rd(4, 32'h0);
        csr_rd(5, 32'd5);
        csr_rd(3, 32'd0);
        csr_rd(7, 32'd0);

        // Zero-length job.
        csr_wr(1, 0);
        csr_wr(2, 0);
        d0 = done_cnt;
        csr_wr(3, 1);
        check("t2_c1_busy",  32'(bus.busy_o), 32'd1);
        check("t2_c1_done",  32'(bus.done_o), 32'd0);
        check("t2_c1_allow", 32'({bus.in_allow_o, bus.out_allow_o}), 32'd0);
        tick();
        check("t2_c2_busy",  32'(bus.busy_o), 32'd1);
        check("t2_c2_done",  32'(bus.done_o), 32'd1);
        check("t2_c2_allow", 32'({bus.in_allow_o, bus.out_allow_o}), 32'd0);
        tick();
        check("t2_c3_busy",  32'(bus.busy_o), 32'd0);
        check("t2_c3_done",  32'(bus.done_o), 32'd0);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Input gate closes after NUM_IN beats despite continuous fires.
        csr_wr(1, 3);
        csr_wr(2, 1);
        d0 = done_cnt;
        csr_wr(3, 1);
        bus.in_fire_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_in_allow_%0d", i), 32'(bus.in_allow_o), 32'(i < 3));
            tick();
        end
        bus.in_fire_i = 1'b0;
        check("t3_in_allow_after", 32'(bus.in_allow_o),  32'd0);
        check("t3_out_allow",      32'(bus.out_allow_o), 32'd1);
        check("t3_busy",           32'(bus.busy_o),      32'd1);
        bus.out_fire_i = 1'b1;
        tick();
        bus.out_fire_i = 1'b0;
        wait_idle("t3_idle_timeout");
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Config writes and START are ignored during a job.
        csr_wr(1, 2);
        csr_wr(2, 1);
        d0 = done_cnt;
        csr_wr(3, 1);
        bus.in_fire_i = 1'b1;
        tick();
        bus.in_fire_i = 1'b0;
        csr_wr(1, 9);
        csr_wr(0, 2);
        csr_wr(3, 1);
        csr_rd(1, 2);
        csr_rd(0, 1);
        check("t4_busy", 32'(bus.busy_o), 32'd1);
        bus.in_fire_i  = 1'b1;
        bus.out_fire_i = 1'b1;
        tick();
        bus.in_fire_i  = 1'b0;
        bus.out_fire_i = 1'b0;
        wait_idle("t4_idle_timeout");
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_mode",        32'(bus.dimc_mode_o), 32'd1);

        // Response back-pressure.
        bus.csr_rsp_ready_i = 1'b0;
        csr_req(2, 32'd0, 1'b0, 32'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t5_req_ready", 32'(bus.csr_req_ready_o), 32'd0);
            check("t5_rsp_valid", 32'(bus.csr_rsp_valid_o), 32'd1);
            check("t5_rsp_hold",  bus.csr_rsp_data_o,       32'd1);
            tick();
        end
        bus.csr_rsp_ready_i = 1'b1;
        wait_rsp();

        // Reset mid-job with a read response pending.
        csr_wr(1, 5);
        csr_wr(2, 5);
        csr_wr(3, 1);
        bus.in_fire_i = 1'b1;
        tick();
        bus.in_fire_i = 1'b0;
        d0 = done_cnt;
        bus.csr_rsp_ready_i = 1'b0;
        csr_req(4, 32'd0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        tick();
        check_all_zero("t6");
        rst = 1'b0;
        bus.csr_rsp_ready_i = 1'b1;
        repeat (3) tick();
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        csr_rd(4, 32'd0);
        csr_rd(0, 32'd0);
        csr_rd(1, 32'd0);
        csr_rd(5, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
